// File: rtl/ft245_sdram_writer.sv
// Purpose: FT245 sync-FIFO byte stream -> packet parser -> 16-entry word FIFO -> SDRAM write port.
// Latency: a word is presented on app_wr_* the cycle after its HI byte is accepted.
// Backpressure: app_wr_ack pops the FIFO; FT245 reads pause while fewer than 3 FIFO slots are free.
//
// Ports:
//   clk, reset             shared clock, synchronous active-high reset
//   ft_rxf, ft_d           FT245 RXF# (low = byte available) and read data
//   ft_oe, ft_rd           FT245 OE# / RD#, active low, registered
//   app_wr_req/addr/data   SDRAM write request with show-ahead FIFO head
//   app_wr_ack             one-cycle accept pulse from the SDRAM controller
//   busy                   packet in progress or FIFO not empty
//   sync_err               one-cycle pulse per byte discarded while hunting sync
//   words_written          count of accepted writes, wraps at 2^16
module ft245_sdram_writer #(
  parameter int          ADDR_W    = 22,
  parameter int          FIFO_LOG2 = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ft_rxf,
  input  logic [7:0]        ft_d,
  output logic              ft_oe,
  output logic              ft_rd,
  output logic              app_wr_req,
  output logic [ADDR_W-1:0] app_wr_addr,
  output logic [15:0]       app_wr_data,
  input  logic              app_wr_ack,
  output logic              busy,
  output logic              sync_err,
  output logic [15:0]       words_written
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } word_t;

  typedef enum logic [1:0] {R_IDLE, R_OE, R_READ} rstate_t;
  typedef enum logic [2:0] {P_SYNC, P_A0, P_A1, P_A2, P_L0, P_L1, P_DLO, P_DHI} pstate_t;

  // ---------------- word FIFO state ----------------
  word_t                mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic [FIFO_LOG2:0]   free;
  logic                 full;
  logic                 push, pop;
  word_t                push_dat;
  word_t                head;

  assign free = (FIFO_LOG2+1)'(DEPTH) - count;
  assign full = (count == (FIFO_LOG2+1)'(DEPTH));

  // ---------------- FT245 read FSM ----------------
  rstate_t rstate, rstate_nxt;
  logic    byte_vld;

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (!ft_rxf && free >= (FIFO_LOG2+1)'(3)) rstate_nxt = R_OE;
      R_OE:    rstate_nxt = R_READ;
      // Leaving at free<=2 still leaves room for a word completed by the
      // byte taken on the exit edge plus one more already in flight.
      R_READ:  if (ft_rxf || free <= (FIFO_LOG2+1)'(2)) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate <= R_IDLE;
      ft_oe  <= 1'b1;
      ft_rd  <= 1'b1;
    end else begin
      rstate <= rstate_nxt;
      ft_oe  <= (rstate_nxt == R_IDLE);
      ft_rd  <= (rstate_nxt != R_READ);
    end
  end

  // A byte is taken on every edge where RD# is low and data is still available,
  // including the edge on which the FSM leaves R_READ.
  assign byte_vld = !ft_rd && !ft_rxf;

  // ---------------- packet parser ----------------
  pstate_t           pstate, pstate_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [15:0]       cnt_q, cnt_nxt;
  logic [7:0]        lo_q, lo_nxt;
  logic [23:0]       addr_ext;
  logic              sync_err_nxt;

  always_comb begin
    pstate_nxt   = pstate;
    addr_nxt     = addr_q;
    cnt_nxt      = cnt_q;
    lo_nxt       = lo_q;
    push         = 1'b0;
    push_dat     = '0;
    sync_err_nxt = 1'b0;
    // Header address bytes land in a 24-bit view; bits above ADDR_W drop on truncation.
    addr_ext     = 24'(addr_q);
    if (byte_vld) begin
      case (pstate)
        P_SYNC: begin
          if (ft_d == SYNC_BYTE) pstate_nxt = P_A0;
          else                   sync_err_nxt = 1'b1;
        end
        P_A0: begin
          addr_ext[7:0] = ft_d;
          addr_nxt      = ADDR_W'(addr_ext);
          pstate_nxt    = P_A1;
        end
        P_A1: begin
          addr_ext[15:8] = ft_d;
          addr_nxt       = ADDR_W'(addr_ext);
          pstate_nxt     = P_A2;
        end
        P_A2: begin
          addr_ext[23:16] = ft_d;
          addr_nxt        = ADDR_W'(addr_ext);
          pstate_nxt      = P_L0;
        end
        P_L0: begin
          cnt_nxt    = {cnt_q[15:8], ft_d};
          pstate_nxt = P_L1;
        end
        P_L1: begin
          cnt_nxt    = {ft_d, cnt_q[7:0]};
          pstate_nxt = ({ft_d, cnt_q[7:0]} == 16'd0) ? P_SYNC : P_DLO;
        end
        P_DLO: begin
          lo_nxt     = ft_d;
          pstate_nxt = P_DHI;
        end
        P_DHI: begin
          push          = 1'b1;
          push_dat.addr = addr_q;
          push_dat.data = {ft_d, lo_q};
          addr_nxt      = addr_q + 1'b1;
          cnt_nxt       = cnt_q - 16'd1;
          pstate_nxt    = (cnt_q == 16'd1) ? P_SYNC : P_DLO;
        end
        default: pstate_nxt = P_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pstate   <= P_SYNC;
      addr_q   <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      sync_err <= 1'b0;
    end else begin
      pstate   <= pstate_nxt;
      addr_q   <= addr_nxt;
      cnt_q    <= cnt_nxt;
      lo_q     <= lo_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  // ---------------- word FIFO / write side ----------------
  assign pop = app_wr_ack && app_wr_req;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      words_written <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        words_written <= words_written + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign app_wr_req  = (count != '0);
  // Head is forced to zero when empty so stale RAM never shows on the port.
  assign app_wr_addr = app_wr_req ? head.addr : '0;
  assign app_wr_data = app_wr_req ? head.data : '0;
  assign busy        = (pstate != P_SYNC) || app_wr_req;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule
